// File: rtl/circular_queue_nw.sv
// ============================================================================
// circular_queue_nw : in-order issue queue with multi-lane enqueue, condition
// wakeup and ROB-age partial flush.                             Revision 1.0
// ============================================================================
`default_nettype none

module circular_queue_nw #(
    parameter int DEPTH           = 8,
    parameter int DATA_WIDTH      = 248,
    parameter int CONDITION_WIDTH = 2,
    parameter int ENQ_WIDTH       = 2,
    parameter int WB_PORTS        = 2,
    parameter int ROBID_WIDTH     = 7,
    parameter int ROBID_LSB       = 241
) (
    input  logic                                            clock,
    input  logic                                            reset_n,
    input  logic [ENQ_WIDTH-1:0]                            enqueue_valid,
    output logic                                            enqueue_ready,
    input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0]            enqueue_data,
    input  logic [ENQ_WIDTH-1:0][CONDITION_WIDTH-1:0]       enqueue_condition,
    output logic                                            dequeue_valid,
    input  logic                                            dequeue_ready,
    output logic [DATA_WIDTH-1:0]                           dequeue_data,
    output logic [CONDITION_WIDTH-1:0]                      dequeue_condition,
    output logic [$clog2(DEPTH):0]                          dequeue_selfid,
    input  logic                                            flush_valid,
    input  logic [ROBID_WIDTH-1:0]                          flush_robid,
    input  logic [WB_PORTS-1:0]                             update_condition_valid,
    input  logic [WB_PORTS-1:0][ROBID_WIDTH-1:0]            update_condition_robid,
    input  logic [WB_PORTS-1:0][CONDITION_WIDTH-1:0]        update_condition_mask,
    input  logic [WB_PORTS-1:0][CONDITION_WIDTH-1:0]        update_condition_data,
    output logic [$clog2(DEPTH):0]                          count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] READY_MAX = PW'(DEPTH - ENQ_WIDTH);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DATA_WIDTH-1:0]      data_q [DEPTH];
    logic [DATA_WIDTH-1:0]      data_d [DEPTH];
    logic [CONDITION_WIDTH-1:0] cond_q [DEPTH];
    logic [CONDITION_WIDTH-1:0] cond_d [DEPTH];
    logic [PW-1:0]              enq_ptr_q, enq_ptr_d;
    logic [PW-1:0]              deq_ptr_q, deq_ptr_d;

    logic [AW-1:0] head;
    logic          enq_fire;
    logic          deq_fire;

    // Ports apply in ascending order so a higher port overrides shared bits.
    function automatic logic [CONDITION_WIDTH-1:0] wake(
        input logic [ROBID_WIDTH-1:0]     rob,
        input logic [CONDITION_WIDTH-1:0] cond
    );
        logic [CONDITION_WIDTH-1:0] res;
        res = cond;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (update_condition_valid[p] && (update_condition_robid[p] == rob)) begin
                res = (res & ~update_condition_mask[p])
                    | (update_condition_data[p] & update_condition_mask[p]);
            end
        end
        return res;
    endfunction

    function automatic logic younger(input logic [ROBID_WIDTH-1:0] rob);
        return (rob[ROBID_WIDTH-1] ^ flush_robid[ROBID_WIDTH-1])
             ^ (rob[ROBID_WIDTH-2:0] > flush_robid[ROBID_WIDTH-2:0]);
    endfunction

    assign head          = deq_ptr_q[AW-1:0];
    assign count_out     = enq_ptr_q - deq_ptr_q;
    assign enqueue_ready = (count_out <= READY_MAX);
    assign enq_fire      = enqueue_ready & enqueue_valid[0] & ~flush_valid;
    assign deq_fire      = dequeue_valid & dequeue_ready;

    assign dequeue_valid     = valid_q[head] & (&cond_q[head]) & ~flush_valid;
    assign dequeue_data      = data_q[head];
    assign dequeue_condition = cond_q[head];
    assign dequeue_selfid    = deq_ptr_q;

    always_comb begin
        logic [PW-1:0] survivors;
        logic [AW-1:0] slot;
        survivors = '0;
        slot      = '0;
        valid_d   = valid_q;
        data_d    = data_q;
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            cond_d[i] = valid_q[i] ? wake(data_q[i][ROBID_LSB +: ROBID_WIDTH], cond_q[i])
                                   : cond_q[i];
        end
        if (flush_valid) begin
            // Younger entries are always a tail suffix, so survivors rebase the tail.
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    if (younger(data_q[i][ROBID_LSB +: ROBID_WIDTH])) begin
                        valid_d[i] = 1'b0;
                    end else begin
                        survivors = survivors + PW'(1);
                    end
                end
            end
            enq_ptr_d = deq_ptr_q + survivors;
        end else begin
            if (deq_fire) begin
                valid_d[head] = 1'b0;
                deq_ptr_d     = deq_ptr_q + PW'(1);
            end
            if (enq_fire) begin
                for (int k = 0; k < ENQ_WIDTH; k++) begin
                    if (enqueue_valid[k]) begin
                        slot         = AW'(enq_ptr_q + PW'(k));
                        valid_d[slot] = 1'b1;
                        data_d[slot]  = enqueue_data[k];
                        cond_d[slot]  = wake(enqueue_data[k][ROBID_LSB +: ROBID_WIDTH],
                                             enqueue_condition[k]);
                        enq_ptr_d     = enq_ptr_d + PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q   <= '0;
            data_q    <= '{default: '0};
            cond_q    <= '{default: '0};
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            cond_q    <= cond_d;
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
        end
    end

endmodule

`default_nettype wire
